regfile_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 32×32 register file. Merges the fixed-latency fast path (ALU) and a buffered long-latency path (load/mul-div) onto the register file's single write port. Tracks pending long-latency destinations so decode stalls on RAW/WAW hazards. Sits between execute/memory write-back and the register file write port; decode consumes `issue_stall`.

---
 rtl/regfile_wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/regfile_wb_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regfile_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FAST = 2'd1,
        SRC_LONG = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency write-back results; head is read
// combinationally so a drain can be registered straight into the write port.
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [36:0]
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: merges fast and long result paths onto one register
// file write port and keeps a busy scoreboard for long-latency destinations.
// Optional long-path starvation guard enabled by defining WB_STARVE_GUARD_EN.
module regfile_wb_scheduler
    import regfile_wb_pkg::*;
#(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    input  logic                  issue_long,
    output logic                  issue_stall,
    input  logic                  fw_valid,
    input  logic [REG_ADDR_W-1:0] fw_rd,
    input  logic [XLEN-1:0]       fw_data,
    output logic                  fw_ready,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    output logic                  REG_write_enable,
    output logic [REG_ADDR_W-1:0] REG_write_address,
    output logic [XLEN-1:0]       REG_write_value
);

    localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

    if (LQ_DEPTH < 2 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("regfile_wb_scheduler: LQ_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [5:0]          busy_count;
    logic                long_hazard;
    logic                set_busy;
    logic                clear_busy;
    logic                from_long_reg;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_en;
    logic                pop_en;
    wb_req_t             push_req;
    wb_req_t             fifo_head;

    logic                guard_force;
    wb_src_e             src_next;
    logic [REG_ADDR_W-1:0] wr_addr_next;
    logic [XLEN-1:0]     wr_data_next;

    // ---------------- scoreboard ----------------
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count = busy_count + {5'b0, busy_reg[i]};
        end
    end

    // Reserve FIFO room for every outstanding long result before issuing another.
    assign long_hazard = (int'(fifo_count) + int'(busy_count)) >= LQ_DEPTH;
    assign issue_stall = issue_valid && (busy_reg[issue_rs1] || busy_reg[issue_rs2]
                         || (issue_rd_we && busy_reg[issue_rd])
                         || (issue_long && issue_rd_we && long_hazard));
    assign set_busy    = issue_valid && !issue_stall && issue_long && issue_rd_we;
    assign clear_busy  = REG_write_enable && from_long_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                assign busy_next[gi] = (set_busy && issue_rd == REG_ADDR_W'(gi)) ? 1'b1 :
                                       (clear_busy && REG_write_address == REG_ADDR_W'(gi)) ? 1'b0 :
                                       busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // ---------------- long-path FIFO ----------------
    assign lu_ready = !fifo_full;
    assign push_en  = lu_valid && !fifo_full && (lu_rd != '0);
    assign push_req = '{rd: lu_rd, data: lu_data};
    assign pop_en   = (src_next == SRC_LONG);

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .T     (wb_req_t)
    ) u_lq (
        .clk       (SYS_clk),
        .rst_n     (SYS_reset),
        .push      (push_en),
        .push_data (push_req),
        .pop       (pop_en),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- starvation guard ----------------
`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_reg;
    logic [SC_W-1:0] starve_next;

    assign guard_force = !fifo_empty && (starve_reg == SC_W'(STARVE_LIMIT));
    assign fw_ready    = !guard_force;

    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || src_next == SRC_LONG) begin
            starve_next = '0;
        end else if (src_next == SRC_FAST) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    assign guard_force = 1'b0;
    assign fw_ready    = 1'b1;
`endif

    // ---------------- arbiter and write port ----------------
    // A fast request to x0 is consumed without winning, so the FIFO may still drain.
    always_comb begin
        src_next = SRC_NONE;
        if (guard_force) begin
            src_next = SRC_LONG;
        end else if (fw_valid && fw_rd != '0) begin
            src_next = SRC_FAST;
        end else if (!fifo_empty) begin
            src_next = SRC_LONG;
        end
    end

    always_comb begin
        wr_addr_next = '0;
        wr_data_next = '0;
        case (src_next)
            SRC_FAST: begin
                wr_addr_next = fw_rd;
                wr_data_next = fw_data;
            end
            SRC_LONG: begin
                wr_addr_next = fifo_head.rd;
                wr_data_next = fifo_head.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            REG_write_enable  <= 1'b0;
            REG_write_address <= '0;
            REG_write_value   <= '0;
            from_long_reg     <= 1'b0;
        end else begin
            REG_write_enable  <= (src_next != SRC_NONE);
            REG_write_address <= wr_addr_next;
            REG_write_value   <= wr_data_next;
            from_long_reg     <= (src_next == SRC_LONG);
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: queue-based reference model,
// scoreboard of expected register writes, directed and random phases.
module tb_regfile_wb_scheduler;
    import regfile_wb_pkg::*;

    localparam int LQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b0;
    logic        issue_valid, issue_rd_we, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        fw_valid, fw_ready;
    logic [4:0]  fw_rd;
    logic [31:0] fw_data;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        REG_write_enable;
    logic [4:0]  REG_write_address;
    logic [31:0] REG_write_value;

    always #5 SYS_clk = ~SYS_clk;

    regfile_wb_scheduler #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_long(issue_long),
        .issue_stall(issue_stall),
        .fw_valid(fw_valid), .fw_rd(fw_rd), .fw_data(fw_data), .fw_ready(fw_ready),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .REG_write_enable(REG_write_enable), .REG_write_address(REG_write_address),
        .REG_write_value(REG_write_value)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge SYS_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    wb_req_t     lq[$];
    logic [31:0] m_busy;
    bit          m_we, m_long;
    logic [4:0]  m_addr;
    int          m_lost;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DUT write is matched against the oldest expected write.
    always @(negedge SYS_clk) begin
        if (SYS_reset && REG_write_enable) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: x%0d = 0x%08h, nothing expected (cycle %0d)",
                         REG_write_address, REG_write_value, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write x%0d = 0x%08h at cycle %0d", REG_write_address, REG_write_value, cyc);
                chk("wr_cycle", cyc, mon_e.cyc);
                chk("wr_addr", REG_write_address, mon_e.rd);
                chk("wr_data", REG_write_value, mon_e.data);
            end
        end
    end

    task automatic model_reset();
        lq.delete();
        exp_q.delete();
        m_busy = '0;
        m_we   = 0;
        m_long = 0;
        m_addr = '0;
        m_lost = 0;
    endtask

    // One clock of the reference: check combinational outputs, predict the write, advance state.
    task automatic model_step();
        int  sz = lq.size();
        int  bc = $countones(m_busy);
        bit  force_g = 0;
        bit  exp_lu_ready = (sz < LQ_DEPTH);
        bit  exp_stall;
        bit  fast_win;
        exp_t e;
        wb_req_t h;
`ifdef WB_STARVE_GUARD_EN
        force_g = (m_lost == STARVE_LIMIT) && (sz > 0);
`endif
        exp_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2]
                    || (issue_rd_we && m_busy[issue_rd])
                    || (issue_long && issue_rd_we && (sz + bc >= LQ_DEPTH)));
        chk("lu_ready", lu_ready, exp_lu_ready);
        chk("issue_stall", issue_stall, exp_stall);
        chk("fw_ready", fw_ready, !force_g);

        if (m_we && m_long) m_busy[m_addr] = 1'b0;
        if (issue_valid && !exp_stall && issue_long && issue_rd_we && issue_rd != 0)
            m_busy[issue_rd] = 1'b1;

        fast_win = !force_g && fw_valid && (fw_rd != 0);
        if (fast_win) begin
            e = '{cyc: cyc + 1, rd: fw_rd, data: fw_data};
            exp_q.push_back(e);
            m_we = 1; m_long = 0; m_addr = fw_rd;
        end else if (sz > 0) begin
            h = lq.pop_front();
            e = '{cyc: cyc + 1, rd: h.rd, data: h.data};
            exp_q.push_back(e);
            m_we = 1; m_long = 1; m_addr = h.rd;
        end else begin
            m_we = 0; m_long = 0;
        end

        if (sz == 0 || !fast_win) m_lost = 0;
        else m_lost++;

        if (lu_valid && exp_lu_ready && lu_rd != 0) lq.push_back('{rd: lu_rd, data: lu_data});
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge SYS_clk);
        @(negedge SYS_clk);
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd_we = 0; issue_long = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        fw_valid = 0; fw_rd = 0; fw_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
    endtask

    task automatic issue_long_rd(input logic [4:0] rd);
        clear_inputs();
        issue_valid = 1; issue_long = 1; issue_rd_we = 1; issue_rd = rd;
        tick();
        clear_inputs();
    endtask

    function automatic logic [4:0] pick_lu_rd();
        logic [4:0] r = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 32; i++) begin
                if (m_busy[(int'(r) + i) % 32]) return 5'((int'(r) + i) % 32);
            end
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        model_reset();
        SYS_reset = 0;
        repeat (3) @(negedge SYS_clk);
        issue_valid = 1; issue_rs1 = 3; issue_rs2 = 4;
        #1;
        chk("rst_we", REG_write_enable, 0);
        chk("rst_addr", REG_write_address, 0);
        chk("rst_value", REG_write_value, 0);
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_fw_ready", fw_ready, 1);
        chk("rst_issue_stall", issue_stall, 0);
        clear_inputs();
        @(negedge SYS_clk);
        SYS_reset = 1;

        // Fast write
        fw_valid = 1; fw_rd = 3; fw_data = 32'hDEADBEEF;
        tick();
        clear_inputs();
        #1;
        chk("fast_we", REG_write_enable, 1);
        chk("fast_addr", REG_write_address, 3);
        chk("fast_value", REG_write_value, 32'hDEADBEEF);
        tick();

        // RAW stall on a long destination
        issue_long_rd(9);
        issue_valid = 1; issue_rd_we = 1; issue_rd = 1; issue_rs1 = 9;
        lu_valid = 1; lu_rd = 9; lu_data = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("raw_stall", issue_stall, (k < 3) ? 1 : 0);
            if (k == 2) begin
                chk("raw_wr_addr", REG_write_address, 9);
                chk("raw_wr_value", REG_write_value, 32'h1234);
            end
            tick();
            lu_valid = 0;
        end
        clear_inputs();

        // Fast/long collision
        issue_long_rd(6);
        fw_valid = 1; fw_rd = 4; fw_data = 32'hAAAA0004;
        lu_valid = 1; lu_rd = 6; lu_data = 32'h6666;
        tick();
        clear_inputs();
        issue_valid = 1; issue_rs1 = 6;
        #1;
        chk("coll_first_addr", REG_write_address, 4);
        chk("coll_busy6_c1", issue_stall, 1);
        tick();
        #1;
        chk("coll_second_addr", REG_write_address, 6);
        chk("coll_second_value", REG_write_value, 32'h6666);
        chk("coll_busy6_c2", issue_stall, 1);
        tick();
        #1;
        chk("coll_busy6_clear", issue_stall, 0);
        tick();
        clear_inputs();

        // x0 long result is discarded
        lu_valid = 1; lu_rd = 0; lu_data = 32'hBAD0BAD0;
        tick();
        clear_inputs();
        #1;
        chk("x0_no_write_c1", REG_write_enable, 0);
        chk("x0_lu_ready", lu_ready, 1);
        tick();
        #1;
        chk("x0_no_write_c2", REG_write_enable, 0);
        tick();

        // Full FIFO with the fast path hogging the port
        for (int i = 0; i < 4; i++) begin
            fw_valid = 1; fw_rd = 5'(1 + i); fw_data = $urandom;
            lu_valid = 1; lu_rd = 5'(10 + i); lu_data = 32'hF000_0000 + i;
            tick();
        end
        lu_valid = 1; lu_rd = 20; lu_data = 32'h5555;
        for (int i = 0; i < 2; i++) begin
            fw_valid = 1; fw_rd = 5'(21 + i); fw_data = $urandom;
            #1;
            chk("full_lu_ready", lu_ready, 0);
            tick();
        end
        fw_valid = 0;
        tick();
        #1;
        chk("full_lu_ready_after_pop", lu_ready, 1);
        tick();
        clear_inputs();
        repeat (8) tick();

`ifdef WB_STARVE_GUARD_EN
        // Starvation guard
        lu_valid = 1; lu_rd = 15; lu_data = 32'h15151515;
        tick();
        clear_inputs();
        for (int k = 1; k <= 10; k++) begin
            fw_valid = 1; fw_rd = 2; fw_data = 32'h2000_0000 + k;
            #1;
            chk("starve_fw_ready", fw_ready, (k == 9) ? 0 : 1);
            if (k == 10) chk("starve_head_written", REG_write_address, 15);
            tick();
        end
        clear_inputs();
        repeat (4) tick();
`endif

        // Reset mid-burst: 3 FIFO entries, busy {5,7}
        issue_long_rd(5);
        issue_long_rd(7);
        for (int i = 0; i < 4; i++) begin
            fw_valid = 1; fw_rd = 2; fw_data = 32'h0200_0000 + i;
            lu_valid = (i < 3); lu_rd = 5'(10 + i); lu_data = 32'hC000_0000 + i;
            tick();
        end
        #2;
        SYS_reset = 0;
        model_reset();
        clear_inputs();
        issue_valid = 1; issue_rs1 = 5; issue_rs2 = 7; issue_rd_we = 1; issue_rd = 7;
        #1;
        chk("midrst_we", REG_write_enable, 0);
        chk("midrst_addr", REG_write_address, 0);
        chk("midrst_value", REG_write_value, 0);
        chk("midrst_lu_ready", lu_ready, 1);
        chk("midrst_busy_clear", issue_stall, 0);
        clear_inputs();
        @(negedge SYS_clk);
        SYS_reset = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("postrst_no_write", REG_write_enable, 0);
            tick();
        end

        // Random traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1   = 5'($urandom_range(0, 31));
            issue_rs2   = 5'($urandom_range(0, 31));
            issue_rd    = 5'($urandom_range(0, 31));
            issue_rd_we = 1'($urandom_range(0, 1));
            issue_long  = ($urandom_range(0, 2) == 0);
            fw_valid    = ($urandom_range(0, 2) != 0);
            fw_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            fw_data     = $urandom;
            lu_valid    = 1'($urandom_range(0, 1));
            lu_rd       = pick_lu_rd();
            lu_data     = $urandom;
            tick();
        end

        clear_inputs();
        repeat (12) tick();
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
